// File: rtl/spi_frame_capture.sv
// Passive SPI frame sniffer feeding the MITM logic stage.
// Synchronises the tapped SCLK/CS_N/MOSI/MISO pins into sys_clk, deserialises
// DATA_SIZE-bit words on both data lines and presents each completed pair with a
// one-cycle eval pulse. It never drives the SPI bus.
// Ports:
//   sys_clk, rst        system clock (posedge) and synchronous active-high reset
//   sclk_in, cs_n_in    tapped SPI clock / chip select (asynchronous)
//   mosi_in, miso_in    tapped data lines (asynchronous)
//   real_mosi_data      last complete MOSI word, held until the next word
//   real_miso_data      last complete MISO word, held until the next word
//   eval                1-cycle pulse: new word pair valid on the data outputs
//   frame_active        high while a CS frame is being captured
//   frame_abort         1-cycle pulse: CS released in the middle of a word
//   word_count          complete words seen in the current CS frame
module spi_frame_capture #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CPOL      = 0,
  parameter int unsigned CPHA      = 0,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 sclk_in,
  input  logic                 cs_n_in,
  input  logic                 mosi_in,
  input  logic                 miso_in,
  output logic [DATA_SIZE-1:0] real_mosi_data,
  output logic [DATA_SIZE-1:0] real_miso_data,
  output logic                 eval,
  output logic                 frame_active,
  output logic                 frame_abort,
  output logic [CNT_WIDTH-1:0] word_count
);

  localparam int unsigned BIT_W = (DATA_SIZE > 2) ? $clog2(DATA_SIZE) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_SIZE - 1);
  localparam logic SCLK_IDLE   = 1'(CPOL);
  // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling one.
  localparam logic SAMPLE_RISE = ~(1'(CPOL) ^ 1'(CPHA));

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Synchroniser stages; sclk has a third stage for edge detection.
  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2;
  logic mosi_s1, mosi_s2;
  logic miso_s1, miso_s2;

  logic [0:0]           state, state_d;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [DATA_SIZE-1:0] mosi_sr, mosi_sr_d, miso_sr, miso_sr_d;
  logic [DATA_SIZE-1:0] mosi_shifted, miso_shifted;
  logic                 word_done, word_done_d;
  logic [DATA_SIZE-1:0] real_mosi_d, real_miso_d;
  logic                 eval_d, frame_active_d, frame_abort_d;
  logic [CNT_WIDTH-1:0] word_count_d;
  logic                 sclk_rise, sclk_fall, sample_edge;

  // Two-stage synchronisers, loaded with bus-idle values on reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sclk_s1 <= SCLK_IDLE;
      sclk_s2 <= SCLK_IDLE;
      sclk_s3 <= SCLK_IDLE;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk_in;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= cs_n_in;
      cs_s2   <= cs_s1;
      mosi_s1 <= mosi_in;
      mosi_s2 <= mosi_s1;
      miso_s1 <= miso_in;
      miso_s2 <= miso_s1;
    end
  end

  assign sclk_rise   = sclk_s2 & ~sclk_s3;
  assign sclk_fall   = ~sclk_s2 & sclk_s3;
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;

  // Shift the synchronised data bit in from the configured end.
  always_comb begin
    if (MSB_FIRST != 0) begin
      mosi_shifted = {mosi_sr[DATA_SIZE-2:0], mosi_s2};
      miso_shifted = {miso_sr[DATA_SIZE-2:0], miso_s2};
    end else begin
      mosi_shifted = {mosi_s2, mosi_sr[DATA_SIZE-1:1]};
      miso_shifted = {miso_s2, miso_sr[DATA_SIZE-1:1]};
    end
  end

  // State and capture registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      bit_cnt        <= '0;
      mosi_sr        <= '0;
      miso_sr        <= '0;
      word_done      <= 1'b0;
      real_mosi_data <= '0;
      real_miso_data <= '0;
      eval           <= 1'b0;
      frame_active   <= 1'b0;
      frame_abort    <= 1'b0;
      word_count     <= '0;
    end else begin
      state          <= state_d;
      bit_cnt        <= bit_cnt_d;
      mosi_sr        <= mosi_sr_d;
      miso_sr        <= miso_sr_d;
      word_done      <= word_done_d;
      real_mosi_data <= real_mosi_d;
      real_miso_data <= real_miso_d;
      eval           <= eval_d;
      frame_active   <= frame_active_d;
      frame_abort    <= frame_abort_d;
      word_count     <= word_count_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state;
    bit_cnt_d     = bit_cnt;
    mosi_sr_d     = mosi_sr;
    miso_sr_d     = miso_sr;
    word_done_d   = 1'b0;
    real_mosi_d   = real_mosi_data;
    real_miso_d   = real_miso_data;
    eval_d        = 1'b0;
    frame_abort_d = 1'b0;
    word_count_d  = word_count;

    // A word completed on the previous cycle: publish it one cycle later so the
    // shift registers already hold the final bit.
    if (word_done) begin
      real_mosi_d  = mosi_sr;
      real_miso_d  = miso_sr;
      eval_d       = 1'b1;
      word_count_d = word_count + CNT_WIDTH'(1);
    end

    case (state)
      ST_IDLE: begin
        if (!cs_s2) begin
          state_d      = ST_ACTIVE;
          bit_cnt_d    = '0;
          mosi_sr_d    = '0;
          miso_sr_d    = '0;
          word_count_d = '0;
        end
      end
      ST_ACTIVE: begin
        // CS release wins over a coincident sample edge.
        if (cs_s2) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          if (bit_cnt != '0) begin
            frame_abort_d = 1'b1;
          end
        end else if (sample_edge) begin
          mosi_sr_d = mosi_shifted;
          miso_sr_d = miso_shifted;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_d   = '0;
            word_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    frame_active_d = (state_d == ST_ACTIVE);
  end

endmodule

// File: tb/tb_spi_frame_capture.sv
// Directed bench for spi_frame_capture: four instances cover mode 0 MSB-first,
// modes 3 and 1 LSB-first, and a 2-bit word counter for wrap-around.
module tb_spi_frame_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] sclk_v, cs_v, mosi_v, miso_v;
  logic [3:0][7:0] rmosi, rmiso;
  logic [3:0] ev, act, abt;
  logic [15:0] wc0, wc1, wc2;
  logic [1:0]  wc3;

  spi_frame_capture u0 (
    .sys_clk(clk), .rst(rst), .sclk_in(sclk_v[0]), .cs_n_in(cs_v[0]),
    .mosi_in(mosi_v[0]), .miso_in(miso_v[0]), .real_mosi_data(rmosi[0]),
    .real_miso_data(rmiso[0]), .eval(ev[0]), .frame_active(act[0]),
    .frame_abort(abt[0]), .word_count(wc0));

  spi_frame_capture #(.CPOL(1), .CPHA(1), .MSB_FIRST(0)) u1 (
    .sys_clk(clk), .rst(rst), .sclk_in(sclk_v[1]), .cs_n_in(cs_v[1]),
    .mosi_in(mosi_v[1]), .miso_in(miso_v[1]), .real_mosi_data(rmosi[1]),
    .real_miso_data(rmiso[1]), .eval(ev[1]), .frame_active(act[1]),
    .frame_abort(abt[1]), .word_count(wc1));

  spi_frame_capture #(.CPOL(0), .CPHA(1), .MSB_FIRST(0)) u2 (
    .sys_clk(clk), .rst(rst), .sclk_in(sclk_v[2]), .cs_n_in(cs_v[2]),
    .mosi_in(mosi_v[2]), .miso_in(miso_v[2]), .real_mosi_data(rmosi[2]),
    .real_miso_data(rmiso[2]), .eval(ev[2]), .frame_active(act[2]),
    .frame_abort(abt[2]), .word_count(wc2));

  spi_frame_capture #(.CNT_WIDTH(2)) u3 (
    .sys_clk(clk), .rst(rst), .sclk_in(sclk_v[3]), .cs_n_in(cs_v[3]),
    .mosi_in(mosi_v[3]), .miso_in(miso_v[3]), .real_mosi_data(rmosi[3]),
    .real_miso_data(rmiso[3]), .eval(ev[3]), .frame_active(act[3]),
    .frame_abort(abt[3]), .word_count(wc3));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int edge_cyc = 0;
  int ev_cyc0 = 0;
  int ev_cnt[4];
  int ab_cnt[4];
  logic [15:0] mq[$];
  logic [1:0]  wq3[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ev[k]) ev_cnt[k]++;
      if (abt[k]) ab_cnt[k]++;
    end
    if (ev[0]) begin
      ev_cyc0 = cyc;
      mq.push_back({rmosi[0], rmiso[0]});
    end
    if (ev[3]) wq3.push_back(wc3);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive nbits of a word; edge_cyc records the last sample edge.
  task automatic spi_bits(input int id, input logic [7:0] mo, input logic [7:0] mi,
                          input int nbits, input bit lsb, input logic cpol, input bit cpha);
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = lsb ? i : 7 - i;
      if (!cpha) begin
        repeat (2) @(negedge clk);
        mosi_v[id] = mo[b];
        miso_v[id] = mi[b];
        repeat (3) @(negedge clk);
        sclk_v[id] = ~cpol;
        if (i == nbits - 1) edge_cyc = cyc;
        repeat (4) @(negedge clk);
        sclk_v[id] = cpol;
      end else begin
        repeat (3) @(negedge clk);
        sclk_v[id] = ~cpol;
        repeat (2) @(negedge clk);
        mosi_v[id] = mo[b];
        miso_v[id] = mi[b];
        repeat (3) @(negedge clk);
        sclk_v[id] = cpol;
        if (i == nbits - 1) edge_cyc = cyc;
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_low(input int id);
    cs_v[id] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_high(input int id);
    repeat (2) @(negedge clk);
    cs_v[id] = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int e0, a0, n;
    logic [7:0] w;
    logic [1:0] wexp [5];
    wexp[0] = 2'd1; wexp[1] = 2'd2; wexp[2] = 2'd3; wexp[3] = 2'd0; wexp[4] = 2'd1;

    rst = 1'b1;
    sclk_v = 4'b0010;
    cs_v = 4'hF;
    mosi_v = 4'h0;
    miso_v = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_mosi", 32'(rmosi[0]), 32'h0);
    check("rst_miso", 32'(rmiso[0]), 32'h0);
    check("rst_eval", 32'(ev[0]), 32'h0);
    check("rst_active", 32'(act[0]), 32'h0);
    check("rst_abort", 32'(abt[0]), 32'h0);
    check("rst_count", 32'(wc0), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single mode-0 word with latency.
    cs_low(0);
    check("active_on", 32'(act[0]), 32'h1);
    e0 = ev_cnt[0];
    spi_bits(0, 8'hA5, 8'h3C, 8, 1'b0, 1'b0, 1'b0);
    check("m0_evals", 32'(ev_cnt[0] - e0), 32'd1);
    check("m0_latency", 32'(ev_cyc0 - edge_cyc), 32'd4);
    check("m0_mosi", 32'(rmosi[0]), 32'hA5);
    check("m0_miso", 32'(rmiso[0]), 32'h3C);
    check("m0_count", 32'(wc0), 32'd1);
    cs_high(0);
    check("active_off", 32'(act[0]), 32'h0);
    check("count_hold", 32'(wc0), 32'd1);

    // Back-to-back words in one frame.
    a0 = ab_cnt[0];
    n = mq.size();
    cs_low(0);
    for (int k = 0; k < 3; k++) begin
      w = 8'(k + 1);
      spi_bits(0, w, ~w, 8, 1'b0, 1'b0, 1'b0);
    end
    check("b2b_evals", 32'(mq.size() - n), 32'd3);
    for (int k = 0; k < 3; k++) begin
      w = 8'(k + 1);
      if (mq.size() > n + k) check("b2b_data", 32'(mq[n + k]), 32'({w, ~w}));
    end
    check("b2b_count", 32'(wc0), 32'd3);
    cs_high(0);
    check("b2b_noabort", 32'(ab_cnt[0] - a0), 32'd0);
    check("b2b_inactive", 32'(act[0]), 32'h0);

    // Abort after a partial word.
    cs_low(0);
    spi_bits(0, 8'h12, 8'h21, 8, 1'b0, 1'b0, 1'b0);
    e0 = ev_cnt[0];
    a0 = ab_cnt[0];
    spi_bits(0, 8'hFF, 8'hFF, 5, 1'b0, 1'b0, 1'b0);
    cs_high(0);
    check("abort_pulse", 32'(ab_cnt[0] - a0), 32'd1);
    check("abort_noeval", 32'(ev_cnt[0] - e0), 32'd0);
    check("abort_hold", 32'(rmosi[0]), 32'h12);
    cs_low(0);
    spi_bits(0, 8'h34, 8'h43, 8, 1'b0, 1'b0, 1'b0);
    check("after_abort_mosi", 32'(rmosi[0]), 32'h34);
    check("after_abort_miso", 32'(rmiso[0]), 32'h43);
    check("after_abort_count", 32'(wc0), 32'd1);

    // Reset in the middle of a word.
    spi_bits(0, 8'hC3, 8'h00, 4, 1'b0, 1'b0, 1'b0);
    e0 = ev_cnt[0];
    a0 = ab_cnt[0];
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_mosi", 32'(rmosi[0]), 32'h0);
    check("mid_rst_miso", 32'(rmiso[0]), 32'h0);
    check("mid_rst_count", 32'(wc0), 32'h0);
    check("mid_rst_active", 32'(act[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cs_high(0);
    check("mid_rst_noeval", 32'(ev_cnt[0] - e0), 32'd0);
    check("mid_rst_noabort", 32'(ab_cnt[0] - a0), 32'd0);
    cs_low(0);
    spi_bits(0, 8'h5A, 8'hA5, 8, 1'b0, 1'b0, 1'b0);
    cs_high(0);
    check("post_rst_evals", 32'(ev_cnt[0] - e0), 32'd1);
    check("post_rst_mosi", 32'(rmosi[0]), 32'h5A);

    // Mode 3, LSB first.
    e0 = ev_cnt[1];
    cs_low(1);
    spi_bits(1, 8'h80, 8'h01, 8, 1'b1, 1'b1, 1'b1);
    cs_high(1);
    check("m3_mosi", 32'(rmosi[1]), 32'h80);
    check("m3_miso", 32'(rmiso[1]), 32'h01);
    check("m3_evals", 32'(ev_cnt[1] - e0), 32'd1);

    // Mode 1, LSB first.
    e0 = ev_cnt[2];
    cs_low(2);
    spi_bits(2, 8'h80, 8'h01, 8, 1'b1, 1'b0, 1'b1);
    cs_high(2);
    check("m1_mosi", 32'(rmosi[2]), 32'h80);
    check("m1_miso", 32'(rmiso[2]), 32'h01);
    check("m1_evals", 32'(ev_cnt[2] - e0), 32'd1);

    // 2-bit word counter wraps.
    n = wq3.size();
    cs_low(3);
    for (int k = 0; k < 5; k++) begin
      spi_bits(3, 8'(k + 16), 8'h00, 8, 1'b0, 1'b0, 1'b0);
    end
    cs_high(3);
    check("wrap_evals", 32'(wq3.size() - n), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (wq3.size() > n + k) check("wrap_count", 32'(wq3[n + k]), 32'(wexp[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
